// File: rtl/ba_nibble_seq.sv
// ba_nibble_seq
//   Adds two WIDTH-bit operands one nibble at a time, LSB first, through a
//   single external 4-bit adder that has no carry-in. When a nibble has an
//   incoming carry, the nibble takes a second pass through the same adder
//   with b = 4'b0001 (state INC).
//
//   Handshake: start is sampled only while ready=1 (state IDLE). After all
//   nibbles are processed, done pulses for one cycle. result and carry_out
//   are then valid and hold until the next accepted start.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start              request, sampled only when ready=1
//   op_a, op_b         operands, captured on the accepted start
//   ready              high in IDLE
//   busy               high in ADD or INC
//   done               one-cycle pulse, result/carry_out valid
//   result, carry_out  registered sum and final carry
//   add_a, add_b       driven to the external adder
//   add_sum, add_cout  returned from the external adder
module ba_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    INC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic             carry;  // carry into the current nibble
  logic [3:0]       tmp;    // first-pass sum waiting for its +1 pass
  logic             c1;     // first-pass carry of the nibble now in INC

  // Status outputs are decoded directly from the state register.
  assign ready = (state == IDLE);
  assign busy  = (state == ADD) || (state == INC);
  assign done  = (state == DONE);

  // Adder inputs: operand nibbles in ADD, (tmp, 1) in INC, zero otherwise.
  always_comb begin
    add_a = 4'd0;
    add_b = 4'd0;
    case (state)
      ADD: begin
        add_a = a_q[{idx, 2'b00} +: 4];
        add_b = b_q[{idx, 2'b00} +: 4];
      end
      INC: begin
        add_a = tmp;
        add_b = 4'b0001;
      end
      default: begin
        add_a = 4'd0;
        add_b = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      tmp       <= 4'd0;
      c1        <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q       <= op_a;
            b_q       <= op_b;
            result    <= '0;
            carry_out <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            state     <= ADD;
          end
        end

        ADD: begin
          if (!carry) begin
            // No incoming carry: the first pass is the final nibble value.
            result[{idx, 2'b00} +: 4] <= add_sum;
            carry                     <= add_cout;
            if (idx == LAST_IDX) begin
              carry_out <= add_cout;
              state     <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ADD;
            end
          end else begin
            // Incoming carry: park the partial sum and add 1 next cycle.
            tmp   <= add_sum;
            c1    <= add_cout;
            state <= INC;
          end
        end

        INC: begin
          // Only one of c1/add_cout can be set, so OR gives the nibble carry.
          result[{idx, 2'b00} +: 4] <= add_sum;
          carry                     <= c1 | add_cout;
          if (idx == LAST_IDX) begin
            carry_out <= c1 | add_cout;
            state     <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ADD;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ba_nibble_seq.sv
// Bench for ba_nibble_seq (WIDTH=16) with a behavioural 4-bit adder model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_ba_nibble_seq;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic [3:0]       add_sum;
  logic             add_cout;

  int checks = 0;
  int passed = 0;

  logic [7:0] trace_q[$];  // {add_a, add_b} for every busy cycle

  ba_nibble_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  // External 4-bit adder, no carry-in.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drivers
  // Call at a sample point with ready=1; returns in cycle 1 of the operation.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit hold);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
  endtask

  // Bounded wait for done. cyc is the cycle number (from accept) where done
  // is high, or -1 on timeout. Records the adder inputs of every busy cycle.
  task automatic wait_done(output int cyc, output int nbusy);
    cyc   = -1;
    nbusy = 0;
    trace_q.delete();
    for (int n = 1; n <= 40; n++) begin
      if (busy) begin
        nbusy++;
        trace_q.push_back({add_a, add_b});
      end
      if (done) begin
        cyc = n;
        break;
      end
      step();
    end
  endtask

  // Tests
  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    step();
    step();
    checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    checks++; if (result !== 16'h0000) $display("FAIL reset_result: got %h expected 0000", result); else passed++;
    checks++; if (carry_out !== 1'b0) $display("FAIL reset_cout: got %b expected 0", carry_out); else passed++;
    checks++; if ({add_a, add_b} !== 8'h00) $display("FAIL reset_adder: got %h expected 00", {add_a, add_b}); else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_no_carry();
    int cyc, nb;
    start_op(16'h1234, 16'h4321, 1'b0);
    wait_done(cyc, nb);
    checks++; if (cyc !== 5) $display("FAIL nc_latency: got %0d expected 5", cyc); else passed++;
    checks++; if (nb !== 4) $display("FAIL nc_busy: got %0d expected 4", nb); else passed++;
    checks++; if (result !== 16'h5555) $display("FAIL nc_result: got %h expected 5555", result); else passed++;
    checks++; if (carry_out !== 1'b0) $display("FAIL nc_cout: got %b expected 0", carry_out); else passed++;
    step();
    checks++; if (ready !== 1'b1 || done !== 1'b0) $display("FAIL nc_idle: got ready=%b done=%b expected 1 0", ready, done); else passed++;
    checks++; if (result !== 16'h5555) $display("FAIL nc_hold: got %h expected 5555", result); else passed++;
  endtask

  task automatic test_one_inc();
    int cyc, nb;
    start_op(16'h0006, 16'h000A, 1'b0);
    wait_done(cyc, nb);
    checks++; if (cyc !== 6) $display("FAIL inc1_latency: got %0d expected 6", cyc); else passed++;
    checks++; if (nb !== 5) $display("FAIL inc1_busy: got %0d expected 5", nb); else passed++;
    checks++; if (result !== 16'h0010) $display("FAIL inc1_result: got %h expected 0010", result); else passed++;
    checks++; if (carry_out !== 1'b0) $display("FAIL inc1_cout: got %b expected 0", carry_out); else passed++;
    step();
  endtask

  task automatic test_ripple();
    int cyc, nb;
    logic [7:0] exp_tr [7];
    exp_tr = '{8'hF1, 8'hF0, 8'hF1, 8'hF0, 8'hF1, 8'hF0, 8'hF1};
    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_done(cyc, nb);
    checks++; if (cyc !== 8) $display("FAIL rip_latency: got %0d expected 8", cyc); else passed++;
    checks++; if (nb !== 7) $display("FAIL rip_busy: got %0d expected 7", nb); else passed++;
    checks++; if (result !== 16'h0000) $display("FAIL rip_result: got %h expected 0000", result); else passed++;
    checks++; if (carry_out !== 1'b1) $display("FAIL rip_cout: got %b expected 1", carry_out); else passed++;
    for (int i = 0; i < 7; i++) begin
      logic [7:0] got;
      got = (i < trace_q.size()) ? trace_q[i] : 8'hxx;
      checks++; if (got !== exp_tr[i]) $display("FAIL rip_adder%0d: got %h expected %h", i, got, exp_tr[i]); else passed++;
    end
    checks++; if ({add_a, add_b} !== 8'h00) $display("FAIL rip_done_adder: got %h expected 00", {add_a, add_b}); else passed++;
    step();
  endtask

  task automatic test_ignore_busy();
    int ndone, done_cyc;
    ndone    = 0;
    done_cyc = -1;
    start_op(16'hC7F9, 16'h7A08, 1'b0);
    for (int n = 1; n <= 14; n++) begin
      if (done) begin
        ndone++;
        done_cyc = n;
      end
      // Extra start pulses mid-operation and in the DONE cycle; garbage operands.
      start = (n == 2 || n == 4 || done) ? 1'b1 : 1'b0;
      op_a  = 16'(n * 16'h1111);
      op_b  = 16'hFFFF;
      step();
    end
    start = 1'b0;
    checks++; if (ndone !== 1) $display("FAIL ign_done_count: got %0d expected 1", ndone); else passed++;
    checks++; if (done_cyc !== 8) $display("FAIL ign_latency: got %0d expected 8", done_cyc); else passed++;
    checks++; if (result !== 16'h4201) $display("FAIL ign_result: got %h expected 4201", result); else passed++;
    checks++; if (carry_out !== 1'b1) $display("FAIL ign_cout: got %b expected 1", carry_out); else passed++;
    checks++; if (ready !== 1'b1) $display("FAIL ign_ready: got %b expected 1", ready); else passed++;
  endtask

  task automatic test_reset_mid();
    int cyc, nb, ndone;
    ndone = 0;
    start_op(16'hFFFF, 16'h0001, 1'b0);
    step();  // cycle 2: ADD nibble 1
    checks++; if (busy !== 1'b1) $display("FAIL rm_busy_pre: got %b expected 1", busy); else passed++;
    step();  // cycle 3: INC nibble 1
    checks++; if ({add_a, add_b} !== 8'hF1) $display("FAIL rm_in_inc: got %h expected f1", {add_a, add_b}); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (ready !== 1'b1 || busy !== 1'b0) $display("FAIL rm_state: got ready=%b busy=%b expected 1 0", ready, busy); else passed++;
    checks++; if (result !== 16'h0000 || carry_out !== 1'b0) $display("FAIL rm_result: got %h/%b expected 0000/0", result, carry_out); else passed++;
    step();
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (done) ndone++;
      step();
    end
    checks++; if (ndone !== 0) $display("FAIL rm_no_done: got %0d expected 0", ndone); else passed++;
    start_op(16'h0002, 16'h0001, 1'b0);
    wait_done(cyc, nb);
    checks++; if (cyc !== 5) $display("FAIL rm_after_latency: got %0d expected 5", cyc); else passed++;
    checks++; if (result !== 16'h0003) $display("FAIL rm_after_result: got %h expected 0003", result); else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    int cyc, nb;
    start_op(16'h1111, 16'h1111, 1'b1);
    op_a = 16'h8000;
    op_b = 16'h8000;
    wait_done(cyc, nb);
    checks++; if (cyc !== 5) $display("FAIL b2b_lat1: got %0d expected 5", cyc); else passed++;
    checks++; if (result !== 16'h2222) $display("FAIL b2b_result1: got %h expected 2222", result); else passed++;
    step();
    checks++; if (ready !== 1'b1) $display("FAIL b2b_idle: got %b expected 1", ready); else passed++;
    step();
    checks++; if (busy !== 1'b1) $display("FAIL b2b_accept: got %b expected 1", busy); else passed++;
    start = 1'b0;
    wait_done(cyc, nb);
    checks++; if (cyc !== 5) $display("FAIL b2b_lat2: got %0d expected 5", cyc); else passed++;
    checks++; if (result !== 16'h0000) $display("FAIL b2b_result2: got %h expected 0000", result); else passed++;
    checks++; if (carry_out !== 1'b1) $display("FAIL b2b_cout2: got %b expected 1", carry_out); else passed++;
    step();
  endtask

  initial begin
    test_reset();
    test_no_carry();
    test_one_inc();
    test_ripple();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
